// File: rtl/stim_pkg.sv
// Shared types and widths for the stimulus queue.
package stim_pkg;

  localparam int unsigned STIM_DATA_W  = 32;
  localparam int unsigned STIM_STALL_W = 16;

  // One stored stimulus word plus its end-of-stream marker.
  typedef struct packed {
    logic [STIM_DATA_W-1:0] data;
    logic                   last;
  } stim_entry_t;

endpackage

// File: rtl/stim_queue_mem.sv
// Entry storage for stim_queue: one synchronous write port, one asynchronous read port.
module stim_queue_mem
  import stim_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  stim_entry_t              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output stim_entry_t              rdata
);

  stim_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stim_queue.sv
// Stimulus FIFO between a test source and a DUT, with end-of-test tracking.
// Define STIM_QUEUE_BYPASS_EN for a same-cycle pass-through when the queue is empty.
module stim_queue
  import stim_pkg::*;
#(
  parameter int unsigned DATA_W = STIM_DATA_W,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic [STIM_STALL_W-1:0]   stall_cnt,
  output logic                      done,
  output logic                      finished
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  stim_entry_t   wr_entry;
  stim_entry_t   head;
  logic          push;
  logic          pop;
  logic          push_store;
  logic          pop_store;
  logic          pop_last;

  // Readiness depends only on registered state, never on out_ready.
  assign in_ready = (count < CW'(DEPTH)) && !finished;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  assign wr_entry.data = STIM_DATA_W'(in_data);
  assign wr_entry.last = in_last;

`ifdef STIM_QUEUE_BYPASS_EN
  // Empty queue presents the incoming word directly; a consumed bypass word is never stored.
  logic bypass;
  assign bypass     = (count == '0) && in_valid && !finished;
  assign out_valid  = (count != '0) || bypass;
  assign out_data   = bypass ? in_data : DATA_W'(head.data);
  assign pop_last   = bypass ? in_last : head.last;
  assign push_store = push && !(bypass && out_ready);
  assign pop_store  = pop && !bypass;
`else
  assign out_valid  = (count != '0);
  assign out_data   = DATA_W'(head.data);
  assign pop_last   = head.last;
  assign push_store = push;
  assign pop_store  = pop;
`endif

  stim_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push_store && !rst),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers, occupancy, stall counter and end-of-test flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
      done      <= 1'b0;
      finished  <= 1'b0;
    end else begin
      if (push_store) wr_ptr <= wr_ptr + AW'(1);
      if (pop_store)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_store, pop_store})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_valid && !in_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STIM_STALL_W'(1);
      done <= pop && pop_last;
      if (pop && pop_last) finished <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stim_queue.sv
// Randomized and directed bench for stim_queue against a queue-based reference model.
module tb_stim_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic [15:0] stall_cnt;
  logic        done;
  logic        finished;

  stim_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .stall_cnt (stall_cnt),
    .done      (done),
    .finished  (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {last, data}, plus flags.
  logic [32:0] m_q [$];
  logic        m_fin   = 1'b0;
  logic        m_done  = 1'b0;
  logic [15:0] m_stall = '0;
  logic        m_known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then advance the model.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic il,
                       input logic ordy, input logic r);
    logic        exp_ready;
    logic        exp_valid;
    logic        byp;
    logic        push;
    logic        pop;
    logic [32:0] head;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; in_last = il; out_ready = ordy;
    #1;
    exp_ready = (m_q.size() < DEPTH) && !m_fin;
    byp = 1'b0;
`ifdef STIM_QUEUE_BYPASS_EN
    byp = (m_q.size() == 0) && iv && !m_fin;
`endif
    exp_valid = (m_q.size() != 0) || byp;
    head = byp ? {il, d} : ((m_q.size() != 0) ? m_q[0] : 33'h0);
    if (m_known) begin
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) check("out_data", 64'(out_data), 64'(head[31:0]));
      check("count", 64'(count), 64'(m_q.size()));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("done", 64'(done), 64'(m_done));
      check("finished", 64'(finished), 64'(m_fin));
    end
    push = iv && exp_ready;
    pop  = exp_valid && ordy;
    if (r) begin
      m_q.delete();
      m_fin   = 1'b0;
      m_done  = 1'b0;
      m_stall = '0;
    end else begin
      m_done = pop && head[32];
      if (iv && !exp_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (push) m_q.push_back({il, d});
      if (pop) void'(m_q.pop_front());
      if (m_done) m_fin = 1'b1;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    do_reset();
    m_known = 1'b1;

    // Reset state
    idle();
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);

    // Three words held, then drained in order
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    idle();
    check("fill3_count", 64'(count), 64'd3);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("drain_w0", 64'(out_data), 64'h11);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("drain_w1", 64'(out_data), 64'h22);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("drain_w2", 64'(out_data), 64'h33);
    idle();
    check("drain_count", 64'(count), 64'd0);

    // Full queue stalls the producer; the held word enters after a pop
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5, 1'b0, 1'b1, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("stall3", 64'(stall_cnt), 64'd3);
    cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    check("after_pop_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("stall_sticky", 64'(stall_cnt), 64'd4);

    // Steady push+pop at count 2 across pointer wrap
    do_reset();
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h102 + 32'(i), 1'b0, 1'b1, 1'b0);
      check("steady_count", 64'(count), 64'd2);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Last-flagged word ends the test; trailing entry still drains
    do_reset();
    cycle(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    idle();
    check("last_done", 64'(done), 64'd1);
    check("last_finished", 64'(finished), 64'd1);
    check("last_in_ready", 64'(in_ready), 64'd0);
    check("last_count", 64'(count), 64'd1);
    cycle(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    idle();
    check("fin_drained", 64'(count), 64'd0);
    check("fin_done_pulse", 64'(done), 64'd0);

    // Mid-stream reset discards entries and ignores a coincident push/pop
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h2FF, 1'b0, 1'b1, 1'b1);
    idle();
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_finished", 64'(finished), 64'd0);
    check("midrst_stall", 64'(stall_cnt), 64'd0);

    // Empty-queue latency
    do_reset();
    cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
`ifdef STIM_QUEUE_BYPASS_EN
    check("byp_valid", 64'(out_valid), 64'd1);
    check("byp_data", 64'(out_data), 64'h55);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("byp_count", 64'(count), 64'd0);
`else
    check("lat_valid0", 64'(out_valid), 64'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("lat_valid1", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_data), 64'h55);
    check("lat_count", 64'(count), 64'd1);
`endif

    // Randomized traffic with occasional last words and resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic r;
      int   bias;
      bias = (i / 500) % 4;
      r = m_fin ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 3) < 3 - (bias == 1 ? 2 : 0),
            $urandom,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) < 2 + (bias == 2 ? 2 : 0) - (bias == 3 ? 2 : 0),
            r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
